// File: rtl/alu16_sequencer.sv
// alu16_sequencer: two-pass 16-bit Z80 ADD/ADC/SBC/INC/DEC sequencer that
// drives an external 8-bit ALU with the low byte, then the high byte, and
// then assembles the 16-bit result and F-register flags.
// Optional feature macro: ALU16_UNDOC_FLAGS_EN (Y/X flags from result bits
// 13/11 for ADD/ADC/SBC; otherwise Y/X pass through from flags_in).
module alu16_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flags_out,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_sub,
    output logic        alu_cin,
    output logic        alu_en,
    input  logic [7:0]  alu_res,
    input  logic        alu_cout,
    input  logic        alu_half,
    input  logic        alu_ov
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADC  = 3'd1,
        OP_SBC  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_RSV5 = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  f_q, f_d;
    logic [7:0]  lo_res_q, lo_res_d;
    logic        lo_carry_q, lo_carry_d;
    logic        lo_zero_q, lo_zero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  flags_q, flags_d;

    logic        is_sub;
    logic        is_incdec;
    logic        uses_carry;
    logic [15:0] hi_result;
    logic [7:0]  hi_flags;

    assign is_sub     = (op_q == OP_SBC) || (op_q == OP_DEC);
    assign is_incdec  = (op_q == OP_INC) || (op_q == OP_DEC);
    assign uses_carry = (op_q == OP_ADC) || (op_q == OP_SBC);

    // Byte-lane drive to the ALU; all zero outside the two passes.
    always_comb begin
        alu_en  = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;
        alu_cin = 1'b0;
        case (state_q)
            S_LO: begin
                alu_en  = 1'b1;
                alu_a   = a_q[7:0];
                alu_b   = is_incdec ? 8'h01 : b_q[7:0];
                alu_sub = is_sub;
                alu_cin = uses_carry ? f_q[0] : 1'b0;
            end
            S_HI: begin
                alu_en  = 1'b1;
                alu_a   = a_q[15:8];
                alu_b   = is_incdec ? 8'h00 : b_q[15:8];
                alu_sub = is_sub;
                alu_cin = lo_carry_q;
            end
            default: ;
        endcase
    end

    // Result and flag assembly from the HI-pass ALU outputs.
    always_comb begin
        hi_result = {alu_res, lo_res_q};
        hi_flags  = f_q;
        case (op_q)
            OP_ADD: begin
                hi_flags[4] = alu_half;
                hi_flags[1] = 1'b0;
                hi_flags[0] = alu_cout;
            end
            OP_ADC, OP_SBC: begin
                hi_flags[7] = alu_res[7];
                hi_flags[6] = lo_zero_q && (alu_res == 8'h00);
                hi_flags[4] = alu_half;
                hi_flags[2] = alu_ov;
                hi_flags[1] = (op_q == OP_SBC);
                hi_flags[0] = alu_cout;
            end
            OP_INC, OP_DEC: ;
            default: hi_result = a_q;
        endcase
`ifdef ALU16_UNDOC_FLAGS_EN
        if ((op_q == OP_ADD) || (op_q == OP_ADC) || (op_q == OP_SBC)) begin
            hi_flags[5] = alu_res[5];
            hi_flags[3] = alu_res[3];
        end
`endif
    end

    // Next-state and next-output logic for the IDLE -> LO -> HI sequence.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        lo_res_d   = lo_res_q;
        lo_carry_d = lo_carry_q;
        lo_zero_d  = lo_zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_t'(op);
                    a_d     = a;
                    b_d     = b;
                    f_d     = flags_in;
                    busy_d  = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                lo_res_d   = alu_res;
                lo_carry_d = alu_cout;
                lo_zero_d  = (alu_res == 8'h00);
                state_d    = S_HI;
            end
            S_HI: begin
                result_d = hi_result;
                flags_d  = hi_flags;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= '0;
            lo_res_q   <= '0;
            lo_carry_q <= 1'b0;
            lo_zero_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            f_q        <= f_d;
            lo_res_q   <= lo_res_d;
            lo_carry_q <= lo_carry_d;
            lo_zero_q  <= lo_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_q;

endmodule
